// File: rtl/line_draw_ctrl.sv
// Line command sequencer: loads endpoints into the external bresenham stepper
// and turns every stepped point into a clipped framebuffer write.
module line_draw_ctrl #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int ADDR_W   = 17,
    parameter int COLOR_W  = 3,
    parameter int MAX_LEN  = 512
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [8:0]         cmd_x0,
    input  logic [7:0]         cmd_y0,
    input  logic [8:0]         cmd_x1,
    input  logic [7:0]         cmd_y1,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               abort,
    output logic [8:0]         start_x,
    output logic [7:0]         start_y,
    output logic [8:0]         end_x,
    output logic [7:0]         end_y,
    output logic               set_new,
    output logic               draw_enable,
    input  logic               done,
    input  logic [8:0]         bx,
    input  logic [7:0]         by,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    input  logic               fb_ready,
    output logic               busy,
    output logic [9:0]         line_len,
    output logic               wdog_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_INIT = 2'd2,
        S_DRAW = 2'd3
    } state_t;

    localparam logic [9:0]        X_LIM      = 10'(SCREEN_W);
    localparam logic [8:0]        Y_LIM      = 9'(SCREEN_H);
    localparam logic [9:0]        STEP_LIM   = 10'(MAX_LEN);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SCREEN_W);

    state_t             r_state;
    state_t             w_next;
    logic [8:0]         r_start_x;
    logic [7:0]         r_start_y;
    logic [8:0]         r_end_x;
    logic [7:0]         r_end_y;
    logic [COLOR_W-1:0] r_color;
    logic [9:0]         r_step;
    logic [9:0]         r_line_len;
    logic               r_wdog_err;
    logic [9:0]         w_step_inc;
    logic               w_vis;
    logic               w_adv;
    logic               w_accept;
    logic               w_wdog_hit;
    logic               w_set_new;
    logic               w_draw_en;
    logic               w_fb_we;

    // A clipped point never waits on the framebuffer, so it always advances.
    assign w_vis      = ({1'b0, bx} < X_LIM) && ({1'b0, by} < Y_LIM);
    assign w_adv      = ~w_vis | fb_ready;
    assign w_step_inc = r_step + 10'd1;
    assign w_wdog_hit = (w_step_inc == STEP_LIM) && ~done;
    assign w_accept   = (r_state == S_IDLE) && cmd_valid;

    // Next-state and strobe decode
    always_comb begin
        w_next    = r_state;
        w_set_new = 1'b0;
        w_draw_en = 1'b0;
        w_fb_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_next = S_LOAD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_INIT;
                end
            end
            S_INIT: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_next    = S_DRAW;
                    w_set_new = 1'b1;
                end
            end
            S_DRAW: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_fb_we = w_vis;
                    if (w_adv) begin
                        if (done || w_wdog_hit) begin
                            w_next = S_IDLE;
                        end else begin
                            w_next    = S_DRAW;
                            w_draw_en = 1'b1;
                        end
                    end else begin
                        w_next = S_DRAW;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State, command latches, step counter and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_start_x  <= 9'd0;
            r_start_y  <= 8'd0;
            r_end_x    <= 9'd0;
            r_end_y    <= 8'd0;
            r_color    <= '0;
            r_step     <= 10'd0;
            r_line_len <= 10'd0;
            r_wdog_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_start_x  <= cmd_x0;
                r_start_y  <= cmd_y0;
                r_end_x    <= cmd_x1;
                r_end_y    <= cmd_y1;
                r_color    <= cmd_color;
                r_wdog_err <= 1'b0;
            end
            if (r_state == S_INIT) begin
                r_step <= 10'd0;
            end else if ((r_state == S_DRAW) && !abort && w_adv) begin
                r_step <= w_step_inc;
                if (done) begin
                    r_line_len <= w_step_inc;
                end else if (w_wdog_hit) begin
                    r_wdog_err <= 1'b1;
                end
            end
        end
    end

    // Strobes are masked during reset so no write escapes in the reset cycle.
    assign set_new     = w_set_new & ~rst;
    assign draw_enable = w_draw_en & ~rst;
    assign fb_we       = w_fb_we & ~rst;
    assign fb_addr     = (ADDR_W'(by) * ROW_STRIDE) + ADDR_W'(bx);
    assign fb_data     = r_color;
    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign start_x     = r_start_x;
    assign start_y     = r_start_y;
    assign end_x       = r_end_x;
    assign end_y       = r_end_y;
    assign line_len    = r_line_len;
    assign wdog_err    = r_wdog_err;

endmodule

// File: tb/tb_line_draw_ctrl.sv
// Scoreboard bench for line_draw_ctrl with a behavioural bresenham stepper.
module tb_line_draw_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_x0;
    logic [7:0]  cmd_y0;
    logic [8:0]  cmd_x1;
    logic [7:0]  cmd_y1;
    logic [2:0]  cmd_color;
    logic        abort;
    logic [8:0]  start_x;
    logic [7:0]  start_y;
    logic [8:0]  end_x;
    logic [7:0]  end_y;
    logic        set_new;
    logic        draw_enable;
    logic        done;
    logic [8:0]  bx;
    logic [7:0]  by;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_ready;
    logic        busy;
    logic [9:0]  line_len;
    logic        wdog_err;

    typedef struct packed {
        logic [16:0] addr;
        logic [2:0]  data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_w;
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  last_wr_cyc = 0;
    int  wr_cnt = 0;
    bit  stuck = 1'b0;
    bit  prev_stall = 1'b0;
    logic [16:0] prev_addr = 17'd0;

    always #5 clk = ~clk;

    line_draw_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color), .abort(abort),
        .start_x(start_x), .start_y(start_y), .end_x(end_x), .end_y(end_y),
        .set_new(set_new), .draw_enable(draw_enable), .done(done),
        .bx(bx), .by(by), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_ready(fb_ready), .busy(busy), .line_len(line_len), .wdog_err(wdog_err)
    );

    // Behavioural bresenham stepper
    int m_x = 0, m_y = 0, m_err = 0;
    int g_dx, g_dy, g_sx, g_sy;
    always_comb begin
        g_dx = int'(end_x) - int'(start_x);
        g_sx = (g_dx >= 0) ? 1 : -1;
        if (g_dx < 0) g_dx = -g_dx;
        g_dy = int'(end_y) - int'(start_y);
        g_sy = (g_dy >= 0) ? 1 : -1;
        if (g_dy > 0) g_dy = -g_dy;
    end
    always @(posedge clk) begin
        if (set_new) begin
            m_x   <= int'(start_x);
            m_y   <= int'(start_y);
            m_err <= g_dx + g_dy;
        end else if (draw_enable) begin
            if (2 * m_err >= g_dy) m_x <= m_x + g_sx;
            if (2 * m_err <= g_dx) m_y <= m_y + g_sy;
            m_err <= m_err + ((2 * m_err >= g_dy) ? g_dy : 0) + ((2 * m_err <= g_dx) ? g_dx : 0);
        end
    end
    assign bx   = m_x[8:0];
    assign by   = m_y[7:0];
    assign done = !stuck && (bx == end_x) && (by == end_y);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected visible writes of a line; max_wr truncates for abort/reset cases
    task automatic push_line(input int x0, input int y0, input int x1, input int y1,
                             input int c, input int max_wr, input bit stk, output int len);
        int x, y, dx, dy, sx, sy, err, e2, nw;
        wr_t w;
        x = x0; y = y0; nw = 0; len = 0;
        dx = (x1 >= x0) ? x1 - x0 : x0 - x1;
        dy = (y1 >= y0) ? y0 - y1 : y1 - y0;
        sx = (x1 >= x0) ? 1 : -1;
        sy = (y1 >= y0) ? 1 : -1;
        err = dx + dy;
        forever begin
            if ((x % 512) < 320 && (y % 256) < 240) begin
                if (nw < max_wr) begin
                    w.addr = 17'((y % 256) * 320 + (x % 512));
                    w.data = 3'(c);
                    exp_q.push_back(w);
                end
                nw++;
            end
            len++;
            if (!stk && x == x1 && y == y1) break;
            if (stk && len == 512) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    // Drive a command and return in the first cycle after its acceptance
    task automatic send(input int x0, input int y0, input int x1, input int y1, input int c,
                        input int max_wr, input bit keep, output int len);
        int n;
        push_line(x0, y0, x1, y1, c, max_wr, stuck, len);
        cmd_x0 = 9'(x0); cmd_y0 = 8'(y0); cmd_x1 = 9'(x1); cmd_y1 = 8'(y1);
        cmd_color = 3'(c);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 3000) begin tick(); n++; end
        check_val("accept_tmo", 32'(cmd_ready), 32'd1);
        tick();
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin tick(); n++; end
        check_val("idle_tmo", 32'(busy), 32'd0);
    endtask

    // Write scoreboard and stall monitor
    always @(negedge clk) begin
        if (prev_stall) begin
            check_val("stall_hold_addr", 32'(fb_addr), 32'(prev_addr));
            check_val("stall_hold_we", 32'(fb_we), 32'd1);
        end
        if (fb_we && fb_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_wr", 32'd0, 32'd1);
            end else begin
                mon_w = exp_q.pop_front();
                check_val("wr_addr", 32'(fb_addr), 32'(mon_w.addr));
                check_val("wr_data", 32'(fb_data), 32'(mon_w.data));
            end
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (fb_we && !fb_ready) begin
            check_val("stall_de", 32'(draw_enable), 32'd0);
            prev_stall = 1'b1;
            prev_addr  = fb_addr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int len, len1, len2, wr0;
        rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0; fb_ready = 1'b1;
        cmd_x0 = 9'd0; cmd_y0 = 8'd0; cmd_x1 = 9'd0; cmd_y1 = 8'd0; cmd_color = 3'd0;
        repeat (3) tick();
        check_val("rst_ready", 32'(cmd_ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_we", 32'(fb_we), 32'd0);
        check_val("rst_setnew", 32'(set_new), 32'd0);
        check_val("rst_len", 32'(line_len), 32'd0);
        check_val("rst_wdog", 32'(wdog_err), 32'd0);
        rst = 1'b0;
        tick();

        // (0,0)->(3,0): exact cycle timing
        send(0, 0, 3, 0, 5, 1000, 1'b0, len);
        check_val("c1_busy", 32'(busy), 32'd1);
        check_val("c1_ready", 32'(cmd_ready), 32'd0);
        check_val("c1_setnew", 32'(set_new), 32'd0);
        check_val("c1_endx", 32'(end_x), 32'd3);
        check_val("c1_data", 32'(fb_data), 32'd5);
        tick();
        check_val("c2_setnew", 32'(set_new), 32'd1);
        check_val("c2_we", 32'(fb_we), 32'd0);
        tick();
        check_val("c3_we", 32'(fb_we), 32'd1);
        check_val("c3_addr", 32'(fb_addr), 32'd0);
        repeat (3) tick();
        check_val("c6_we", 32'(fb_we), 32'd1);
        tick();
        check_val("c7_ready", 32'(cmd_ready), 32'd1);
        check_val("len_4", 32'(line_len), 32'd4);
        check_val("q_empty_1", 32'(exp_q.size()), 32'd0);

        // single point
        wr0 = wr_cnt;
        send(10, 10, 10, 10, 2, 1000, 1'b0, len);
        wait_idle();
        check_val("single_len", 32'(line_len), 32'd1);
        check_val("single_wrs", 32'(wr_cnt - wr0), 32'd1);

        // stall on the second pixel for two cycles
        send(0, 0, 2, 2, 6, 1000, 1'b0, len);
        tick(); tick(); tick();
        fb_ready = 1'b0;
        tick(); tick();
        fb_ready = 1'b1;
        wait_idle();
        check_val("stall_len", 32'(line_len), 32'd3);
        check_val("q_empty_2", 32'(exp_q.size()), 32'd0);

        // right-edge clipping
        send(318, 5, 321, 5, 7, 1000, 1'b0, len);
        wait_idle();
        check_val("clip_len", 32'(line_len), 32'd4);
        check_val("q_empty_3", 32'(exp_q.size()), 32'd0);

        // abort on third DRAW cycle
        send(0, 0, 9, 0, 4, 2, 1'b0, len);
        tick(); tick(); tick(); tick();
        abort = 1'b1;
        #1;
        check_val("abort_we", 32'(fb_we), 32'd0);
        check_val("abort_de", 32'(draw_enable), 32'd0);
        tick();
        abort = 1'b0;
        check_val("abort_idle", 32'(busy), 32'd0);
        check_val("abort_len", 32'(line_len), 32'd4);
        check_val("q_empty_4", 32'(exp_q.size()), 32'd0);

        // abort in IDLE does nothing
        abort = 1'b1;
        tick(); tick();
        abort = 1'b0;
        check_val("idle_abort_busy", 32'(busy), 32'd0);
        check_val("idle_abort_len", 32'(line_len), 32'd4);

        // back-to-back with cmd_valid held
        send(0, 1, 4, 3, 3, 1000, 1'b1, len1);
        push_line(3, 7, 0, 4, 1, 1000, 1'b0, len2);
        cmd_x0 = 9'd3; cmd_y0 = 8'd7; cmd_x1 = 9'd0; cmd_y1 = 8'd4; cmd_color = 3'd1;
        begin
            int n;
            n = 0;
            while (!cmd_ready && n < 3000) begin tick(); n++; end
        end
        check_val("b2b_ready", 32'(cmd_ready), 32'd1);
        check_val("b2b_gap", 32'(cyc), 32'(last_wr_cyc + 1));
        check_val("b2b_len1", 32'(line_len), 32'(len1));
        tick();
        cmd_valid = 1'b0;
        check_val("b2b_startx", 32'(start_x), 32'd3);
        check_val("b2b_data", 32'(fb_data), 32'd1);
        wait_idle();
        check_val("b2b_len2", 32'(line_len), 32'(len2));
        check_val("q_empty_5", 32'(exp_q.size()), 32'd0);

        // watchdog: stepper never reports done
        stuck = 1'b1;
        send(0, 0, 5, 0, 3, 1000, 1'b0, len);
        wait_idle();
        stuck = 1'b0;
        check_val("wdog_set", 32'(wdog_err), 32'd1);
        check_val("wdog_len", 32'(line_len), 32'(len2));
        check_val("q_empty_6", 32'(exp_q.size()), 32'd0);
        send(1, 1, 2, 1, 2, 1000, 1'b0, len);
        check_val("wdog_clr", 32'(wdog_err), 32'd0);
        wait_idle();
        check_val("post_wdog_len", 32'(line_len), 32'd2);

        // reset in the middle of a line
        send(0, 0, 9, 0, 5, 2, 1'b0, len);
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        check_val("mrst_busy", 32'(busy), 32'd0);
        check_val("mrst_we", 32'(fb_we), 32'd0);
        check_val("mrst_len", 32'(line_len), 32'd0);
        check_val("mrst_data", 32'(fb_data), 32'd0);
        check_val("mrst_endx", 32'(end_x), 32'd0);
        check_val("mrst_de", 32'(draw_enable), 32'd0);
        rst = 1'b0;
        tick(); tick();
        check_val("q_empty_7", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
